// File: rtl/tv80_pkg.sv
// tv80_pkg
// Shared definitions for the tv80 core slice:
//   - Flag_* : bit positions of the flags inside the F register
//   - alu_op_e : 4-bit operation codes understood by tv80_alu (ALU_Op)
//   - seq_op_e : 2-bit operation select of the 16-bit ALU sequencer
//   - seq_state_e : sequencer state encoding
package tv80_pkg;

  localparam int unsigned Flag_C = 0;
  localparam int unsigned Flag_N = 1;
  localparam int unsigned Flag_P = 2;
  localparam int unsigned Flag_X = 3;
  localparam int unsigned Flag_H = 4;
  localparam int unsigned Flag_Y = 5;
  localparam int unsigned Flag_Z = 6;
  localparam int unsigned Flag_S = 7;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_XOR = 4'd5,
    ALU_OR  = 4'd6,
    ALU_CP  = 4'd7,
    ALU_ROT = 4'd8,
    ALU_BIT = 4'd9,
    ALU_SET = 4'd10,
    ALU_RES = 4'd11,
    ALU_DAA = 4'd12,
    ALU_RLD = 4'd13,
    ALU_RRD = 4'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_ADC16 = 2'b01,
    OP_SBC16 = 2'b10,
    OP_RSVD  = 2'b11
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tv80_alu16_seq_drive.sv
// tv80_alu16_seq_drive
// Pure decode of the sequencer state into the drive for the shared 8-bit ALU.
// Ports:
//   state, op_lat          : current sequencer state and latched operation
//   a_lat, b_lat           : latched 16-bit operands
//   f_lat, f_tmp           : flags at start / flags after the low-byte pass
//   busy, alu_own          : status decodes (alu_own drops for the reserved op)
//   alu_op .. alu_fin      : ALU control and data inputs, all zero outside LO/HI
module tv80_alu16_seq_drive
  import tv80_pkg::*;
(
  input  seq_state_e  state,
  input  seq_op_e     op_lat,
  input  logic [15:0] a_lat,
  input  logic [15:0] b_lat,
  input  logic [7:0]  f_lat,
  input  logic [7:0]  f_tmp,
  output logic        busy,
  output logic        alu_own,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_fin
);

  logic hi_pass;

  assign hi_pass = (state == ST_HI);

  // The high pass always chains through the carry-using opcode. Z16 on the
  // high pass makes the ALU AND its zero result with the low-pass Z, so Z
  // reflects the whole 16-bit result. ADD16 keeps S/Z/P via Arith16 instead.
  always_comb begin
    busy        = 1'b0;
    alu_own     = 1'b0;
    alu_op      = ALU_ADD;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_busa    = 8'h00;
    alu_busb    = 8'h00;
    alu_fin     = 8'h00;
    if (state == ST_LO || state == ST_HI) begin
      busy = 1'b1;
      if (op_lat != OP_RSVD) begin
        alu_own  = 1'b1;
        alu_busa = hi_pass ? a_lat[15:8] : a_lat[7:0];
        alu_busb = hi_pass ? b_lat[15:8] : b_lat[7:0];
        alu_fin  = hi_pass ? f_tmp : f_lat;
        case (op_lat)
          OP_ADD16: begin
            alu_op      = hi_pass ? ALU_ADC : ALU_ADD;
            alu_arith16 = 1'b1;
          end
          OP_ADC16: begin
            alu_op  = ALU_ADC;
            alu_z16 = hi_pass;
          end
          default: begin
            alu_op  = ALU_SBC;
            alu_z16 = hi_pass;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq
// Runs 16-bit ADD/ADC/SBC as two passes (low byte, then high byte) through
// the shared 8-bit tv80_alu, which lives in the parent.
// Ports:
//   clk, reset_n, cen      : clock, async active-low reset, clock enable
//   start, op, op_a, op_b, f_in : request and operands, sampled in IDLE
//   busy, done             : status; done pulses for one enabled cycle
//   result, f_out          : 16-bit result and final flags, held after done
//   alu_own .. alu_fin     : ALU drive, valid while alu_own is high
//   alu_q, alu_fout        : combinational ALU results
module tv80_alu16_seq
  import tv80_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cen,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic        alu_own,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_fin,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_fout
);

  seq_state_e  state;
  seq_op_e     op_lat;
  logic [15:0] a_lat;
  logic [15:0] b_lat;
  logic [7:0]  f_lat;
  logic [7:0]  f_tmp;
  logic [7:0]  res_lo;
  logic        rsvd;

  assign rsvd = (op_lat == OP_RSVD);
  assign done = (state == ST_DONE);

  // The reserved op never touches the ALU; it just passes op_a and f_in
  // through the same LO/HI/DONE walk so the timing matches the real ops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op_lat <= OP_ADD16;
      a_lat  <= 16'h0000;
      b_lat  <= 16'h0000;
      f_lat  <= 8'h00;
      f_tmp  <= 8'h00;
      res_lo <= 8'h00;
      result <= 16'h0000;
      f_out  <= 8'h00;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_lat <= seq_op_e'(op);
            a_lat  <= op_a;
            b_lat  <= op_b;
            f_lat  <= f_in;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          res_lo <= rsvd ? a_lat[7:0] : alu_q;
          f_tmp  <= rsvd ? f_lat : alu_fout;
          state  <= ST_HI;
        end
        ST_HI: begin
          result <= rsvd ? a_lat : {alu_q, res_lo};
          f_out  <= rsvd ? f_lat : alu_fout;
          state  <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  tv80_alu16_seq_drive u_drive (
    .state       (state),
    .op_lat      (op_lat),
    .a_lat       (a_lat),
    .b_lat       (b_lat),
    .f_lat       (f_lat),
    .f_tmp       (f_tmp),
    .busy        (busy),
    .alu_own     (alu_own),
    .alu_op      (alu_op),
    .alu_arith16 (alu_arith16),
    .alu_z16     (alu_z16),
    .alu_busa    (alu_busa),
    .alu_busb    (alu_busb),
    .alu_fin     (alu_fin)
  );

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb_tv80_alu16_seq
// Drives the sequencer with a behavioural 8-bit tv80-style ALU and compares
// every completed operation against a direct 16-bit reference model.
module tb_tv80_alu16_seq;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        start;
  logic [1:0]  op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  f_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic        alu_own;
  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_fin;
  logic [7:0]  alu_q;
  logic [7:0]  alu_fout;

  typedef struct packed {
    logic [15:0] res;
    logic [7:0]  f;
    int          acc;
    int          lat;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  logic  rsvd_active = 1'b0;
  logic  own_seen = 1'b0;

  tv80_alu16_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cen         (cen),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .f_in        (f_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .f_out       (f_out),
    .alu_own     (alu_own),
    .alu_op      (alu_op),
    .alu_arith16 (alu_arith16),
    .alu_z16     (alu_z16),
    .alu_busa    (alu_busa),
    .alu_busb    (alu_busb),
    .alu_fin     (alu_fin),
    .alu_q       (alu_q),
    .alu_fout    (alu_fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit ALU, ADD/ADC/SUB/SBC only, tv80 flag rules.
  function automatic logic [15:0] alu8(input logic [3:0] aop, input logic ar16,
                                       input logic z16, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] fin);
    logic       sub;
    logic       ci;
    logic [7:0] bb;
    logic [4:0] lo;
    logic [4:0] hi;
    logic [7:0] q;
    logic [7:0] f;
    sub = aop[1];
    ci  = sub ^ (aop[0] & fin[0]);
    bb  = sub ? ~b : b;
    lo  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0, ci};
    hi  = {1'b0, a[7:4]} + {1'b0, bb[7:4]} + {4'b0, lo[4]};
    q   = {hi[3:0], lo[3:0]};
    f    = 8'h00;
    f[7] = q[7];
    f[6] = z16 ? ((q == 8'h00) & fin[6]) : (q == 8'h00);
    f[5] = q[5];
    f[4] = lo[4] ^ sub;
    f[3] = q[3];
    f[2] = (a[7] == bb[7]) && (q[7] != a[7]);
    f[1] = sub;
    f[0] = hi[4] ^ sub;
    if (ar16) begin
      f[7] = fin[7];
      f[6] = fin[6];
      f[2] = fin[2];
    end
    if (aop > 4'd3) begin
      q = 8'h00;
      f = 8'h00;
    end
    return {q, f};
  endfunction

  always_comb {alu_q, alu_fout} = alu8(alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_fin);

  // Direct 16-bit reference: {result, flags}.
  function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] fin);
    logic [16:0] s;
    logic [12:0] s12;
    logic [15:0] r;
    logic [7:0]  f;
    logic        cin;
    cin = (o == 2'b00) ? 1'b0 : fin[0];
    f   = 8'h00;
    if (o == 2'b10) begin
      s   = {1'b0, a} - {1'b0, b} - {16'b0, cin};
      s12 = {1'b0, a[11:0]} - {1'b0, b[11:0]} - {12'b0, cin};
    end else begin
      s   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      s12 = {1'b0, a[11:0]} + {1'b0, b[11:0]} + {12'b0, cin};
    end
    r    = s[15:0];
    f[0] = s[16];
    f[1] = (o == 2'b10);
    f[3] = r[11];
    f[4] = s12[12];
    f[5] = r[13];
    case (o)
      2'b00: begin
        f[7] = fin[7];
        f[6] = fin[6];
        f[2] = fin[2];
      end
      2'b01: begin
        f[7] = r[15];
        f[6] = (r == 16'h0000);
        f[2] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'b10: begin
        f[7] = r[15];
        f[6] = (r == 16'h0000);
        f[2] = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: begin
        r = a;
        f = fin;
      end
    endcase
    return {r, f};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one pop per enabled done cycle.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (rsvd_active) own_seen = own_seen | alu_own;
    if (done && cen && reset_n) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        t = sb_tag.pop_front();
        checkOutput({t, "_res"}, {16'h0, result}, {16'h0, e.res});
        checkOutput({t, "_flags"}, {24'h0, f_out}, {24'h0, e.f});
        checkOutput({t, "_lat"}, cyc - e.acc, e.lat);
      end
    end
  end

  // One operation: accept, optional start re-pulse in LO/HI, optional 5-cycle
  // cen stall during HI, optional reset abort during HI.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [15:0] a,
                               input logic [15:0] b, input logic [7:0] f,
                               input bit repulse, input bit stall, input bit abort);
    logic [23:0] r;
    exp_t        e;
    r       = ref16(o, a, b, f);
    start   = 1'b1;
    op      = o;
    op_a    = a;
    op_b    = b;
    f_in    = f;
    @(posedge clk); #1;
    e.res = r[23:8];
    e.f   = r[7:0];
    e.acc = cyc;
    e.lat = stall ? 7 : 2;
    if (!abort) begin
      sb.push_back(e);
      sb_tag.push_back(tag);
    end
    start = repulse;
    if (repulse) begin
      op   = 2'($urandom_range(0, 3));
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      f_in = 8'($urandom);
    end
    @(posedge clk); #1;
    if (abort) begin
      reset_n = 1'b0;
      #1;
      checkOutput({tag, "_rst_res"}, {16'h0, result}, 32'h0);
      checkOutput({tag, "_rst_done"}, {31'h0, done}, 32'h0);
      checkOutput({tag, "_rst_busy"}, {31'h0, busy}, 32'h0);
      checkOutput({tag, "_rst_own"}, {31'h0, alu_own}, 32'h0);
      checkOutput({tag, "_rst_busa"}, {24'h0, alu_busa}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      start   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      return;
    end
    if (stall) begin
      cen = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      cen = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    cen     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    op_a    = 16'h0000;
    op_b    = 16'h0000;
    f_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_result", {16'h0, result}, 32'h0);
    checkOutput("reset_fout", {24'h0, f_out}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_aluop", {28'h0, alu_op}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("add_0fff", 2'b00, 16'h0FFF, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("adc_ffff", 2'b01, 16'hFFFF, 16'h0000, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus("sbc_8000", 2'b10, 16'h8000, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("sbc_0100", 2'b10, 16'h0100, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("add_keep", 2'b00, 16'hFFFF, 16'h0001, 8'hC4, 1'b0, 1'b0, 1'b0);
    applyStimulus("repulse", 2'b01, 16'h1234, 16'h4321, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus("stall", 2'b10, 16'h5000, 16'h7001, 8'h01, 1'b0, 1'b1, 1'b0);

    rsvd_active = 1'b1;
    applyStimulus("rsvd", 2'b11, 16'h1234, 16'hBEEF, 8'hA5, 1'b0, 1'b0, 1'b0);
    rsvd_active = 1'b0;
    checkOutput("rsvd_own", {31'h0, own_seen}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus("rand", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                    8'($urandom), 1'b0, 1'b0, 1'b0);
    end

    applyStimulus("abort", 2'b10, 16'h8000, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_idle_res", {16'h0, result}, 32'h0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("sb_drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
